br_stack_ckpt: RTL

- Complete N-deep branch checkpoint stack for the R10K-style out-of-order core, sitting between dispatch and map table / free list / store queue.
- Allocates a one-hot branch mask bit per dispatched branch and snapshots map table, free-list head and SQ tail into that slot.
- Keeps snapshot ready bits coherent with multiple CDB channels.
- On misprediction, supplies recovery data and squashes dependent checkpoints; on correct resolution, frees the slot and scrubs its bit from all dependency masks.

---
 rtl/br_pkg.sv | 46 ++++
 rtl/br_stack_ckpt_if.sv | 38 +++
 rtl/br_ckpt_slot.sv | 51 +++++
 rtl/br_stack_ckpt.sv | 96 +++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared widths, checkpoint record types and small helpers for the branch
// checkpoint stack.
package br_pkg;

  localparam int BR_NUM    = 4;
  localparam int MT_NUM    = 32;
  localparam int PRF_IDX_W = 6;
  localparam int FL_PTR_W  = 5;
  localparam int SQ_IDX_W  = 3;
  localparam int CDB_NUM   = 2;

  localparam int MT_ENT_W  = PRF_IDX_W + 1;
  localparam int MT_W      = MT_NUM * MT_ENT_W;
  localparam int CDB_TAG_W = CDB_NUM * PRF_IDX_W;

  typedef struct packed {
    logic                 rdy;
    logic [PRF_IDX_W-1:0] tag;
  } mt_ent_t;

  typedef struct packed {
    mt_ent_t [MT_NUM-1:0] mt;
    logic [FL_PTR_W:0]    fl_head;
    logic [SQ_IDX_W:0]    sq_tail;
  } ckpt_t;

  // True when any valid CDB channel broadcasts the given tag.
  function automatic logic cdb_hit(input logic [PRF_IDX_W-1:0] tag,
                                   input logic [CDB_NUM-1:0]   vld,
                                   input logic [CDB_TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_NUM; c++) begin
      if (vld[c] && (tags[c*PRF_IDX_W +: PRF_IDX_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Isolates the lowest set bit (zero in, zero out).
  function automatic logic [BR_NUM-1:0] lsb_onehot(input logic [BR_NUM-1:0] v);
    logic [BR_NUM-1:0] neg;
    neg = ~v + {{(BR_NUM-1){1'b0}}, 1'b1};
    return v & neg;
  endfunction

endpackage

// File: rtl/br_stack_ckpt_if.sv
// Dispatch / resolve / CDB / recovery bundle of the branch checkpoint stack.
interface br_stack_ckpt_if;
  import br_pkg::*;

  logic                   br_dp_vld_i;
  logic [MT_W-1:0]        bak_mt_i;
  logic [FL_PTR_W:0]      bak_fl_head_i;
  logic [SQ_IDX_W:0]      bak_sq_tail_i;
  logic                   br_rs_vld_i;
  logic [BR_NUM-1:0]      br_rs_mask_i;
  logic                   br_rs_wrong_i;
  logic [CDB_NUM-1:0]     cdb_vld_i;
  logic [CDB_TAG_W-1:0]   cdb_tag_i;

  logic [BR_NUM-1:0]      br_mask_o;
  logic [BR_NUM-1:0]      br_new_bit_o;
  logic                   full_o;
  logic                   rc_vld_o;
  logic [MT_W-1:0]        rc_mt_o;
  logic [FL_PTR_W:0]      rc_fl_head_o;
  logic [SQ_IDX_W:0]      rc_sq_tail_o;
  logic [BR_NUM-1:0]      rc_mask_o;

  modport slave (
    input  br_dp_vld_i, bak_mt_i, bak_fl_head_i, bak_sq_tail_i,
           br_rs_vld_i, br_rs_mask_i, br_rs_wrong_i, cdb_vld_i, cdb_tag_i,
    output br_mask_o, br_new_bit_o, full_o, rc_vld_o, rc_mt_o,
           rc_fl_head_o, rc_sq_tail_o, rc_mask_o
  );

  modport master (
    output br_dp_vld_i, bak_mt_i, bak_fl_head_i, bak_sq_tail_i,
           br_rs_vld_i, br_rs_mask_i, br_rs_wrong_i, cdb_vld_i, cdb_tag_i,
    input  br_mask_o, br_new_bit_o, full_o, rc_vld_o, rc_mt_o,
           rc_fl_head_o, rc_sq_tail_o, rc_mask_o
  );

endinterface

// File: rtl/br_ckpt_slot.sv
// One checkpoint slot: snapshot capture with CDB bypass, ready-bit tracking
// while in use, and scrubbing of correctly resolved bits from the dep mask.
module br_ckpt_slot
  import br_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_i,
  input  ckpt_t                bak_ckpt_i,
  input  logic [BR_NUM-1:0]    dep_i,
  input  logic                 in_use_i,
  input  logic [BR_NUM-1:0]    clr_bit_i,
  input  logic [CDB_NUM-1:0]   cdb_vld_i,
  input  logic [CDB_TAG_W-1:0] cdb_tag_i,
  output ckpt_t                ckpt_o,
  output logic [BR_NUM-1:0]    dep_o
);

  ckpt_t             ckpt_q, ckpt_d;
  ckpt_t             cap_val, upd_val;
  logic [BR_NUM-1:0] dep_q, dep_d;

  // Next snapshot: bypassed capture on allocation, otherwise CDB wakeup.
  always_comb begin
    cap_val = bak_ckpt_i;
    upd_val = ckpt_q;
    for (int i = 0; i < MT_NUM; i++) begin
      if (cdb_hit(bak_ckpt_i.mt[i].tag, cdb_vld_i, cdb_tag_i))
        cap_val.mt[i].rdy = 1'b1;
      if (in_use_i && cdb_hit(ckpt_q.mt[i].tag, cdb_vld_i, cdb_tag_i))
        upd_val.mt[i].rdy = 1'b1;
    end
    ckpt_d = cap_i ? cap_val : upd_val;
    dep_d  = cap_i ? dep_i : (dep_q & ~clr_bit_i);
  end

  // Slot state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ckpt_q <= '0;
      dep_q  <= '0;
    end else begin
      ckpt_q <= ckpt_d;
      dep_q  <= dep_d;
    end
  end

  assign ckpt_o = ckpt_q;
  assign dep_o  = dep_q;

endmodule

// File: rtl/br_stack_ckpt.sv
// Branch checkpoint stack: in-flight mask, lowest-free allocation, slot
// array and the misprediction recovery mux.
module br_stack_ckpt
  import br_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  br_stack_ckpt_if.slave   bus
);

  logic [BR_NUM-1:0] cur_mask_q, cur_mask_d;
  logic              wrong;
  logic [BR_NUM-1:0] correct_clr;
  logic [BR_NUM-1:0] live;
  logic [BR_NUM-1:0] grant;
  ckpt_t             bak_ckpt;
  ckpt_t             slot_ckpt [BR_NUM];
  logic [BR_NUM-1:0] slot_dep  [BR_NUM];
  ckpt_t             rc_ckpt;
  logic [BR_NUM-1:0] rc_dep;
  logic              rc_vld;

  // Resolve decode and lowest-free grant; a bit released by a correct
  // resolve this cycle is already reusable.
  always_comb begin
    wrong       = bus.br_rs_vld_i & bus.br_rs_wrong_i;
    correct_clr = (bus.br_rs_vld_i & ~bus.br_rs_wrong_i) ? bus.br_rs_mask_i : '0;
    live        = cur_mask_q & ~correct_clr;
    grant       = (bus.br_dp_vld_i & ~wrong) ? lsb_onehot(~live) : '0;
  end

  // Packs the dispatch snapshot into a checkpoint record.
  always_comb begin
    bak_ckpt         = '0;
    bak_ckpt.mt      = bus.bak_mt_i;
    bak_ckpt.fl_head = bus.bak_fl_head_i;
    bak_ckpt.sq_tail = bus.bak_sq_tail_i;
  end

  for (genvar s = 0; s < BR_NUM; s++) begin : g_slot
    br_ckpt_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .cap_i      (grant[s]),
      .bak_ckpt_i (bak_ckpt),
      .dep_i      (live),
      .in_use_i   (live[s]),
      .clr_bit_i  (correct_clr),
      .cdb_vld_i  (bus.cdb_vld_i),
      .cdb_tag_i  (bus.cdb_tag_i),
      .ckpt_o     (slot_ckpt[s]),
      .dep_o      (slot_dep[s])
    );
  end

  // Selects the resolving slot's snapshot and dependency mask.
  always_comb begin
    rc_ckpt = '0;
    rc_dep  = '0;
    for (int s = 0; s < BR_NUM; s++) begin
      if (bus.br_rs_mask_i[s]) begin
        rc_ckpt = rc_ckpt | slot_ckpt[s];
        rc_dep  = rc_dep  | slot_dep[s];
      end
    end
  end

  // Next in-flight mask: rollback to the dependency mask on a mispredict.
  always_comb begin
    cur_mask_d = wrong ? rc_dep : (live | grant);
  end

  // In-flight mask register.
  always_ff @(posedge clk) begin
    if (rst) cur_mask_q <= '0;
    else     cur_mask_q <= cur_mask_d;
  end

  // Resolve mask must name exactly one live branch.
  always_ff @(posedge clk) begin
    if (!rst && bus.br_rs_vld_i) begin
      assert ($onehot(bus.br_rs_mask_i) && ((bus.br_rs_mask_i & cur_mask_q) != '0));
    end
  end

  assign rc_vld           = wrong & ~rst;
  assign bus.br_mask_o    = cur_mask_q;
  assign bus.br_new_bit_o = grant;
  assign bus.full_o       = &cur_mask_q;
  assign bus.rc_vld_o     = rc_vld;
  assign bus.rc_mt_o      = rc_vld ? rc_ckpt.mt      : '0;
  assign bus.rc_fl_head_o = rc_vld ? rc_ckpt.fl_head : '0;
  assign bus.rc_sq_tail_o = rc_vld ? rc_ckpt.sq_tail : '0;
  assign bus.rc_mask_o    = rc_vld ? rc_dep          : '0;

endmodule
